// File: rtl/msdap_serial_rx.sv
// MSDAP serial front-end: syncs DCLK/Frame/InputL/InputR into Sclk, deserializes stereo words, tags Rj/coef/data, flags silence.
// Latency: SYNC_STAGES + 2 Sclk after the last DCLK fall of a word; no backpressure, word_valid is a one-shot strobe.
module msdap_serial_rx #(
    parameter int WORD_W      = 16,
    parameter int RJ_COUNT    = 16,
    parameter int COEF_COUNT  = 512,
    parameter int SYNC_STAGES = 2,
    parameter int ZERO_RUN    = 800
) (
    input  logic              Sclk,
    input  logic              Reset_n,
    input  logic              Start,
    input  logic              DCLK,
    input  logic              Frame,
    input  logic              InputL,
    input  logic              InputR,
    output logic              word_valid,
    output logic [WORD_W-1:0] word_l,
    output logic [WORD_W-1:0] word_r,
    output logic [1:0]        word_type,
    output logic [9:0]        word_index,
    output logic              load_done,
    output logic              frame_err,
    output logic              sleep
);

    localparam int BW = $clog2(WORD_W + 1);
    localparam int ZW = $clog2(ZERO_RUN + 1);
    localparam logic [9:0]    RJ_LAST   = 10'(RJ_COUNT - 1);
    localparam logic [9:0]    COEF_LAST = 10'(COEF_COUNT - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(WORD_W - 1);

    typedef enum logic [1:0] {
        S_RJ   = 2'b00,
        S_COEF = 2'b01,
        S_DATA = 2'b10
    } state_t;

    logic [SYNC_STAGES-1:0] dclkSync, frameSync, lSync, rSync;
    logic                   dclkPrev;
    logic                   dclkS, frameS, lS, rS, dclkFall;

    state_t            state;
    logic [BW-1:0]     bitCnt;
    logic [WORD_W-1:0] shregL, shregR;
    logic [WORD_W-1:0] nextL, nextR;
    logic [9:0]        idx;
    logic [ZW-1:0]     zeroCnt;
    logic              wordDone;

    assign dclkS    = dclkSync[SYNC_STAGES-1];
    assign frameS   = frameSync[SYNC_STAGES-1];
    assign lS       = lSync[SYNC_STAGES-1];
    assign rS       = rSync[SYNC_STAGES-1];
    assign dclkFall = dclkPrev & ~dclkS;
    assign nextL    = {shregL[WORD_W-2:0], lS};
    assign nextR    = {shregR[WORD_W-2:0], rS};
    assign wordDone = dclkFall && !frameS && (bitCnt == LAST_BIT);

    // All four inputs share one chain depth so each sampled bit lines up with its DCLK edge.
    always_ff @(posedge Sclk or negedge Reset_n) begin
        if (!Reset_n) begin
            dclkSync  <= '0;
            frameSync <= '0;
            lSync     <= '0;
            rSync     <= '0;
            dclkPrev  <= 1'b0;
        end else begin
            dclkSync  <= {dclkSync[SYNC_STAGES-2:0], DCLK};
            frameSync <= {frameSync[SYNC_STAGES-2:0], Frame};
            lSync     <= {lSync[SYNC_STAGES-2:0], InputL};
            rSync     <= {rSync[SYNC_STAGES-2:0], InputR};
            dclkPrev  <= dclkS;
        end
    end

    always_ff @(posedge Sclk or negedge Reset_n) begin
        if (!Reset_n) begin
            state      <= S_RJ;
            bitCnt     <= '0;
            shregL     <= '0;
            shregR     <= '0;
            idx        <= '0;
            zeroCnt    <= '0;
            word_valid <= 1'b0;
            word_l     <= '0;
            word_r     <= '0;
            word_type  <= 2'b00;
            word_index <= '0;
            load_done  <= 1'b0;
            frame_err  <= 1'b0;
            sleep      <= 1'b0;
        end else if (Start) begin
            state      <= S_RJ;
            bitCnt     <= '0;
            shregL     <= '0;
            shregR     <= '0;
            idx        <= '0;
            zeroCnt    <= '0;
            word_valid <= 1'b0;
            word_l     <= '0;
            word_r     <= '0;
            word_type  <= 2'b00;
            word_index <= '0;
            load_done  <= 1'b0;
            frame_err  <= 1'b0;
            sleep      <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (dclkFall) begin
                if (frameS) begin
                    // A Frame bit always opens a fresh word; a partial one in flight is dropped.
                    shregL <= {{(WORD_W-1){1'b0}}, lS};
                    shregR <= {{(WORD_W-1){1'b0}}, rS};
                    bitCnt <= BW'(1);
                    if (bitCnt != '0)
                        frame_err <= 1'b1;
                end else if (bitCnt != '0) begin
                    shregL <= nextL;
                    shregR <= nextR;
                    bitCnt <= wordDone ? '0 : bitCnt + 1'b1;
                end
            end

            if (wordDone) begin
                word_valid <= 1'b1;
                word_l     <= nextL;
                word_r     <= nextR;
                word_type  <= state;
                word_index <= idx;
                case (state)
                    S_RJ: begin
                        if (idx == RJ_LAST) begin
                            state <= S_COEF;
                            idx   <= '0;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                    S_COEF: begin
                        if (idx == COEF_LAST) begin
                            state     <= S_DATA;
                            idx       <= '0;
                            load_done <= 1'b1;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                    S_DATA: begin
                        idx <= idx + 1'b1;
                        if (nextL == '0 && nextR == '0) begin
                            if (zeroCnt != ZW'(ZERO_RUN))
                                zeroCnt <= zeroCnt + 1'b1;
                            if (zeroCnt >= ZW'(ZERO_RUN - 1))
                                sleep <= 1'b1;
                        end else begin
                            zeroCnt <= '0;
                            sleep   <= 1'b0;
                        end
                    end
                    default: state <= S_RJ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_msdap_serial_rx.sv
// Directed bench for msdap_serial_rx: serial frames in, captured words checked against hand-derived expectations.
module tb_msdap_serial_rx;

    logic        Sclk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        Start = 1'b0;
    logic        DCLK = 1'b0;
    logic        Frame = 1'b0;
    logic        InputL = 1'b0;
    logic        InputR = 1'b0;
    logic        word_valid;
    logic [15:0] word_l, word_r;
    logic [1:0]  word_type;
    logic [9:0]  word_index;
    logic        load_done, frame_err, sleep;

    msdap_serial_rx dut (
        .Sclk(Sclk), .Reset_n(Reset_n), .Start(Start), .DCLK(DCLK), .Frame(Frame),
        .InputL(InputL), .InputR(InputR), .word_valid(word_valid), .word_l(word_l),
        .word_r(word_r), .word_type(word_type), .word_index(word_index),
        .load_done(load_done), .frame_err(frame_err), .sleep(sleep)
    );

    always #5 Sclk = ~Sclk;

    typedef struct packed {
        logic [15:0] l;
        logic [15:0] r;
        logic [1:0]  t;
        logic [9:0]  idx;
        logic        ld;
        logic        slp;
    } wrec_t;

    wrec_t q[$];
    int    errPulses = 0;
    int    vectors = 0;
    int    miscompares = 0;
    int    dataCnt = 0;

    always @(negedge Sclk) begin
        if (word_valid)
            q.push_back('{word_l, word_r, word_type, word_index, load_done, sleep});
        if (frame_err)
            errPulses++;
    end

    // One DCLK period = two Sclk periods; data changes with the DCLK rise.
    task automatic sendBit(input logic f, input logic l, input logic r);
        @(posedge Sclk); #2;
        DCLK = 1'b1; Frame = f; InputL = l; InputR = r;
        @(posedge Sclk); #2;
        DCLK = 1'b0;
    endtask

    task automatic sendFrame(input logic [15:0] l, input logic [15:0] r);
        for (int i = 15; i >= 0; i--)
            sendBit(i == 15, l[i], r[i]);
    endtask

    task automatic settle();
        repeat (8) @(posedge Sclk);
        #1;
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        repeat (3) @(posedge Sclk);
        #1;
        vectors++;
        if ({word_valid, word_l, word_r, word_type, word_index, load_done, frame_err, sleep} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got v=%b l=%h r=%h t=%0d idx=%0d ld=%b err=%b slp=%b, want all 0",
                     word_valid, word_l, word_r, word_type, word_index, load_done, frame_err, sleep);
        end
        @(negedge Sclk);
        Reset_n = 1'b1;
        repeat (2) @(posedge Sclk);
    endtask

    task automatic test_single_word();
        wrec_t rec;
        sendFrame(16'h8001, 16'h7FFE);
        settle();
        vectors++;
        if (q.size() != 1) begin
            miscompares++;
            $display("FAIL single_count: got %0d words, want 1", q.size());
        end
        if (q.size() > 0) begin
            rec = q.pop_front();
            vectors++;
            if (rec.l !== 16'h8001 || rec.r !== 16'h7FFE || rec.t !== 2'b00 || rec.idx !== 10'd0 || rec.ld !== 1'b0) begin
                miscompares++;
                $display("FAIL single_word: got l=%h r=%h t=%0d idx=%0d ld=%b, want l=8001 r=7ffe t=0 idx=0 ld=0",
                         rec.l, rec.r, rec.t, rec.idx, rec.ld);
            end
        end
        vectors++;
        if (errPulses != 0) begin
            miscompares++;
            $display("FAIL single_frame_err: got %0d pulses, want 0", errPulses);
        end
        q.delete();
    endtask

    // Words 1..530 after the one above: 15 Rj, 512 coef, 3 data.
    task automatic test_load_sequence();
        wrec_t rec;
        for (int n = 1; n <= 530; n++)
            sendFrame(16'(n * 7 + 3), ~16'(n));
        settle();
        vectors++;
        if (q.size() != 530) begin
            miscompares++;
            $display("FAIL load_count: got %0d words, want 530", q.size());
        end
        for (int n = 1; n <= 530 && q.size() > 0; n++) begin
            logic [1:0]  et;
            int          ei;
            logic [15:0] wl, wr;
            logic        eld;
            rec = q.pop_front();
            if (n < 16) begin et = 2'b00; ei = n; end
            else if (n < 528) begin et = 2'b01; ei = n - 16; end
            else begin et = 2'b10; ei = n - 528; end
            wl  = 16'(n * 7 + 3);
            wr  = ~16'(n);
            eld = (n >= 527);
            vectors++;
            if (rec.l !== wl || rec.r !== wr || rec.t !== et || rec.idx !== 10'(ei) || rec.ld !== eld) begin
                miscompares++;
                $display("FAIL load_word%0d: got l=%h r=%h t=%0d idx=%0d ld=%b, want l=%h r=%h t=%0d idx=%0d ld=%b",
                         n, rec.l, rec.r, rec.t, rec.idx, rec.ld, wl, wr, et, ei, eld);
            end
        end
        vectors++;
        if (load_done !== 1'b1) begin
            miscompares++;
            $display("FAIL load_done_hold: got %b, want 1", load_done);
        end
        q.delete();
        dataCnt = 3;
    endtask

    task automatic test_frame_err();
        wrec_t rec;
        int    base = errPulses;
        sendBit(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++)
            sendBit(1'b0, 1'(i), 1'(~i));
        sendFrame(16'h1234, 16'hABCD);
        settle();
        vectors++;
        if (errPulses - base != 1) begin
            miscompares++;
            $display("FAIL ferr_pulses: got %0d, want 1", errPulses - base);
        end
        vectors++;
        if (q.size() != 1) begin
            miscompares++;
            $display("FAIL ferr_count: got %0d words, want 1", q.size());
        end
        if (q.size() > 0) begin
            rec = q.pop_front();
            vectors++;
            if (rec.l !== 16'h1234 || rec.r !== 16'hABCD || rec.t !== 2'b10 || rec.idx !== 10'(dataCnt)) begin
                miscompares++;
                $display("FAIL ferr_word: got l=%h r=%h t=%0d idx=%0d, want l=1234 r=abcd t=2 idx=%0d",
                         rec.l, rec.r, rec.t, rec.idx, dataCnt);
            end
        end
        q.delete();
        dataCnt++;
    endtask

    // 799 zeros, 0001/0000, 800 zeros, 0001/0000; the data index also passes the 1023->0 wrap here.
    task automatic test_silence_and_wrap();
        wrec_t rec;
        for (int k = 0; k < 1600; k++)
            sendFrame((k == 799) ? 16'h0001 : 16'h0000, 16'h0000);
        settle();
        vectors++;
        if (q.size() != 1600) begin
            miscompares++;
            $display("FAIL silence_count: got %0d words, want 1600", q.size());
        end
        for (int k = 0; k < 1600 && q.size() > 0; k++) begin
            logic [15:0] wl;
            logic        es;
            logic [9:0]  ei;
            rec = q.pop_front();
            wl = (k == 799) ? 16'h0001 : 16'h0000;
            es = (k == 1599);
            ei = 10'((dataCnt + k) % 1024);
            vectors++;
            if (rec.l !== wl || rec.r !== 16'h0000 || rec.t !== 2'b10 || rec.idx !== ei || rec.ld !== 1'b1 || rec.slp !== es) begin
                miscompares++;
                $display("FAIL silence_word%0d: got l=%h r=%h t=%0d idx=%0d ld=%b slp=%b, want l=%h r=0000 t=2 idx=%0d ld=1 slp=%b",
                         k, rec.l, rec.r, rec.t, rec.idx, rec.ld, rec.slp, wl, ei, es);
            end
        end
        dataCnt += 1600;
        vectors++;
        if (sleep !== 1'b1) begin
            miscompares++;
            $display("FAIL sleep_hold: got %b, want 1", sleep);
        end
        sendFrame(16'h0001, 16'h0000);
        settle();
        vectors++;
        if (q.size() != 1) begin
            miscompares++;
            $display("FAIL wake_count: got %0d words, want 1", q.size());
        end
        if (q.size() > 0) begin
            rec = q.pop_front();
            vectors++;
            if (rec.slp !== 1'b0 || rec.idx !== 10'(dataCnt % 1024) || rec.l !== 16'h0001) begin
                miscompares++;
                $display("FAIL wake_word: got slp=%b idx=%0d l=%h, want slp=0 idx=%0d l=0001",
                         rec.slp, rec.idx, rec.l, dataCnt % 1024);
            end
        end
        vectors++;
        if (sleep !== 1'b0) begin
            miscompares++;
            $display("FAIL sleep_clear: got %b, want 0", sleep);
        end
        q.delete();
        dataCnt++;
    endtask

    task automatic test_start_mid_data();
        wrec_t rec;
        int    base = errPulses;
        sendBit(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++)
            sendBit(1'b0, 1'b1, 1'b0);
        @(posedge Sclk); #2;
        Start = 1'b1;
        @(posedge Sclk); #2;
        Start = 1'b0;
        vectors++;
        if ({word_valid, word_l, word_r, word_type, word_index, load_done, frame_err, sleep} !== '0) begin
            miscompares++;
            $display("FAIL start_outputs: got v=%b l=%h r=%h t=%0d idx=%0d ld=%b err=%b slp=%b, want all 0",
                     word_valid, word_l, word_r, word_type, word_index, load_done, frame_err, sleep);
        end
        for (int i = 0; i < 11; i++)
            sendBit(1'b0, 1'b1, 1'b1);
        sendFrame(16'h00FF, 16'hFF00);
        settle();
        vectors++;
        if (q.size() != 1) begin
            miscompares++;
            $display("FAIL start_count: got %0d words, want 1", q.size());
        end
        if (q.size() > 0) begin
            rec = q.pop_front();
            vectors++;
            if (rec.l !== 16'h00FF || rec.r !== 16'hFF00 || rec.t !== 2'b00 || rec.idx !== 10'd0 || rec.ld !== 1'b0) begin
                miscompares++;
                $display("FAIL start_word: got l=%h r=%h t=%0d idx=%0d ld=%b, want l=00ff r=ff00 t=0 idx=0 ld=0",
                         rec.l, rec.r, rec.t, rec.idx, rec.ld);
            end
        end
        vectors++;
        if (errPulses != base) begin
            miscompares++;
            $display("FAIL start_frame_err: got %0d pulses, want 0", errPulses - base);
        end
        q.delete();
    endtask

    task automatic test_reset_mid_coef();
        wrec_t rec;
        int    base = errPulses;
        for (int n = 1; n <= 15; n++)
            sendFrame(16'(16'hC000 + n), 16'(n));
        settle();
        vectors++;
        if (q.size() != 15 || q[q.size()-1].idx !== 10'd15 || q[q.size()-1].t !== 2'b00) begin
            miscompares++;
            $display("FAIL rj_reload: got %0d words, want 15 ending at Rj index 15", q.size());
        end
        q.delete();
        sendBit(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 7; i++)
            sendBit(1'b0, 1'b1, 1'b0);
        @(posedge Sclk); #3;
        Reset_n = 1'b0;
        #1;
        vectors++;
        if ({word_valid, word_l, word_r, word_type, word_index, load_done, frame_err, sleep} !== '0) begin
            miscompares++;
            $display("FAIL async_reset_outputs: got v=%b l=%h r=%h t=%0d idx=%0d ld=%b err=%b slp=%b, want all 0",
                     word_valid, word_l, word_r, word_type, word_index, load_done, frame_err, sleep);
        end
        #9;
        Reset_n = 1'b1;
        for (int i = 0; i < 8; i++)
            sendBit(1'b0, 1'b1, 1'b1);
        sendFrame(16'hC0DE, 16'h0BAD);
        settle();
        vectors++;
        if (q.size() != 1) begin
            miscompares++;
            $display("FAIL reset_count: got %0d words, want 1", q.size());
        end
        if (q.size() > 0) begin
            rec = q.pop_front();
            vectors++;
            if (rec.l !== 16'hC0DE || rec.r !== 16'h0BAD || rec.t !== 2'b00 || rec.idx !== 10'd0 || rec.ld !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_word: got l=%h r=%h t=%0d idx=%0d ld=%b, want l=c0de r=0bad t=0 idx=0 ld=0",
                         rec.l, rec.r, rec.t, rec.idx, rec.ld);
            end
        end
        vectors++;
        if (errPulses != base) begin
            miscompares++;
            $display("FAIL reset_frame_err: got %0d pulses, want 0", errPulses - base);
        end
        q.delete();
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_load_sequence();
        test_frame_err();
        test_silence_and_wrap();
        test_start_mid_data();
        test_reset_mid_coef();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/msdap_serial_rx.md
Name: msdap_serial_rx

Overview:
- Input front-end of the MSDAP datapath. Takes the DCLK-timed serial stereo stream (Frame, InputL, InputR) into the Sclk domain and deserializes 16-bit frames.
- Classifies each word as Rj, coefficient or audio data, and presents parallel words with a one-cycle valid strobe to the Rj/coefficient/data memories and the filter engine.
- Also flags 800-sample silence runs, which drive the processor's sleep mode.

Parameters:
- WORD_W, 16, bits per serial frame.
- RJ_COUNT, 16, Rj words expected after Start/reset.
- COEF_COUNT, 512, coefficient words expected after the Rj words.
- SYNC_STAGES, 2, synchronizer flops on DCLK/Frame/InputL/InputR (minimum 2).
- ZERO_RUN, 800, consecutive all-zero stereo data words that assert sleep.

Ports:
- Sclk  in  1  system clock (26.88 MHz); the only clock.
- Reset_n  in  1  asynchronous active-low reset.
- Start  in  1  synchronous clear of sequencing state; level-sensitive, active high.
- DCLK  in  1  serial data clock (768 kHz), asynchronous to Sclk.
- Frame  in  1  high during the MSB bit period of each frame.
- InputL  in  1  left serial data, MSB first.
- InputR  in  1  right serial data, MSB first.
- word_valid  out  1  one-Sclk pulse; word_l, word_r, word_type and word_index are valid.
- word_l  out  WORD_W  captured left word.
- word_r  out  WORD_W  captured right word.
- word_type  out  2  00 = Rj, 01 = coefficient, 10 = data (11 never driven).
- word_index  out  10  index within the current type; data index wraps modulo 1024.
- load_done  out  1  high once all Rj and coefficient words are received.
- frame_err  out  1  one-Sclk pulse when Frame arrives mid-word.
- sleep  out  1  high while the silence condition holds.

Behaviour:
- **Reset.** Reset_n low (async) forces all outputs to 0, the state to S_RJ, and all counters and shift registers to 0.
- **Start.** Start high at a Sclk edge has the same effect synchronously. It takes priority over any word completing in that cycle.
- **Synchronization.**
  - DCLK, Frame, InputL and InputR each pass through SYNC_STAGES flops, so all four have identical delay.
  - dclk_fall is a one-cycle pulse when the synchronized DCLK is 0 and its previous value was 1.
  - Bits are sampled only on dclk_fall, i.e. mid-bit, because sources change data on the DCLK rising edge.
- **Bit capture at each dclk_fall:**
  - Frame_s = 1 and bit_cnt = 0: start a word; shreg <= {L, R} bits; bit_cnt <= 1.
  - Frame_s = 1 and bit_cnt in 1..15: discard the partial word, pulse frame_err the next cycle, and restart with this bit as the MSB (bit_cnt <= 1).
  - Frame_s = 0 and bit_cnt in 1..15: shift the bits in (MSB first); bit_cnt++.
  - Frame_s = 0 and bit_cnt = 0: idle edge, ignored.
- **Word completion.**
  - When bit_cnt reaches WORD_W, the cycle after that dclk_fall drives word_l, word_r, word_type and word_index and pulses word_valid for exactly 1 cycle.
  - bit_cnt returns to 0 in the same cycle.
  - Word outputs hold their values until the next word_valid.
- **Sequencing FSM:**
  - S_RJ: type 00. index 0..RJ_COUNT-1. After word RJ_COUNT-1 go to S_COEF and reset the index to 0.
  - S_COEF: type 01. index 0..COEF_COUNT-1. After word COEF_COUNT-1 go to S_DATA and reset the index.
  - load_done rises in the same cycle as the last coefficient's word_valid and stays high until reset/Start.
  - S_DATA: type 10. index increments per word, 1023 -> 0 wrap. The block stays in S_DATA until reset/Start.
- **Silence detection** (S_DATA words only):
  - zero_cnt increments when word_l == 0 and word_r == 0, saturating at ZERO_RUN.
  - Any nonzero word clears zero_cnt to 0 and deasserts sleep in the same cycle as that word's word_valid.
  - sleep asserts with the word_valid of the ZERO_RUN-th consecutive zero word.
  - Words in S_RJ and S_COEF never affect zero_cnt.
- **Latency.** Sync delay (SYNC_STAGES) + 1 edge-detect cycle + 1 output cycle after the 16th DCLK falling edge.
- **Reset or Start mid-word.** The partial word is lost without frame_err. The next Frame restarts cleanly as Rj word 0.

Test Plan:
- Reset, then one frame with L = 0x8001, R = 0x7FFE -> exactly one word_valid; word_l = 8001, word_r = 7FFE, word_type = 00, word_index = 0, frame_err = 0.
- 16 Rj + 512 coefficient + 3 data frames -> word_type changes 00->01 at word 16 and 01->10 at word 528; word_index sequence 15, 0 and 511, 0; load_done rises with word 527's word_valid.
- Frame reasserted after 7 bits, then a full frame 0x1234/0xABCD -> one frame_err pulse; next word_valid carries 1234/ABCD with the correct index; no word emitted for the partial frame.
- After load, 800 zero data words then 0x0001/0x0000 -> sleep rises with the 800th word_valid and falls with the nonzero word; a run of 799 zero words never sets sleep.
- 1025 data words -> word_index 1023 followed by 0, then 1.
- Reset_n pulsed low for 10 ns mid-coefficient-word, then Start pulsed mid-data -> all outputs 0 immediately (async) and after Start; next frame reported as word_type = 00, index 0, load_done = 0.
